dram_bram_model: RTL
====================

# dram_bram_model

Synthesizable stand-in for the DDR3 `DRAM` wrapper's user-side interface. It responds to the same request/response handshake that the `RiscV` core drives, so the core can run on boards or in simulation without the MIG controller. Storage is on-chip block RAM. Calibration delay, read latency and write busy time are all configurable.

## Interface
Parameters:
- `APP_ADDR_WIDTH`, default 28. Request address width is `APP_ADDR_WIDTH-1`.
- `APP_DATA_WIDTH`, default 128. Line width in bits.
- `APP_MASK_WIDTH`, default 16. One bit per data byte.
- `MEM_DEPTH`, default 1024. Number of 128-bit lines. Must be a power of two.
- `READ_LATENCY`, default 8. Cycles from read acceptance to first `o_data_valid`. Minimum 1.
- `WRITE_BUSY`, default 2. Cycles `o_busy` stays high after write acceptance. Minimum 1.
- `CALIB_CYCLES`, default 64. Cycles after reset release before calibration completes. Minimum 1.

Ports:
- `clock`, in, 1. Single clock for all logic.
- `reset`, in, 1. Reset is asynchronous and active-high.
- `i_ren`, in, 1. Read request.
- `i_wen`, in, 1. Write request.
- `i_addr`, in, `APP_ADDR_WIDTH-1`. Address in 16-bit units. Bits [2:0] are ignored.
- `i_data`, in, `APP_DATA_WIDTH`. Write data.
- `i_mask`, in, `APP_MASK_WIDTH`. Byte mask. 1 means the byte is not written.
- `i_busy`, in, 1. Requester cannot take read data this cycle.
- `o_init_calib_complete`, out, 1. Model is ready to accept requests.
- `o_data`, out, `APP_DATA_WIDTH`. Read data.
- `o_data_valid`, out, 1. Read data present on `o_data`.
- `o_busy`, out, 1. New requests are not accepted.

## Operation
- Line index is `i_addr[3 +: log2(MEM_DEPTH)]`. Higher address bits alias onto the same lines; no error is raised.
- A request is accepted on any cycle where `(i_ren | i_wen) & !o_busy & o_init_calib_complete`.
- If `i_ren` and `i_wen` are both high, the write is accepted and the read is dropped.
- Write: on the acceptance edge, each byte k with `i_mask[k]=0` is updated from `i_data`. A read accepted afterwards returns the new contents.
- Read: the line is captured at acceptance. Only one read is outstanding at a time.

FSM states:
- CALIB: counter runs. Moves to IDLE when the count reaches `CALIB_CYCLES`.
- IDLE: on a write acceptance, moves to WBUSY. On a read acceptance, moves to RWAIT.
- WBUSY: counts `WRITE_BUSY` cycles, then returns to IDLE.
- RWAIT: counts until `READ_LATENCY` cycles have elapsed since acceptance, then moves to RRESP.
- RRESP: `o_data_valid=1` and `o_data` holds the line. The response is consumed on a cycle with `!i_busy`, then the FSM returns to IDLE. While `i_busy` is high, RRESP holds with `o_data` stable.

Outputs:
- `o_busy=1` in CALIB, WBUSY, RWAIT and RRESP. `o_busy=0` only in IDLE.
- `o_data` keeps its last value outside RRESP.
- Reset mid-operation: all state aborts and the FSM returns to CALIB. The pending read is discarded. Memory contents are retained and are not cleared.

## Timing
- Reset values: `o_init_calib_complete=0`, `o_busy=1`, `o_data_valid=0`, `o_data=0`.
- After reset deasserts, `o_init_calib_complete` rises and `o_busy` falls in cycle `CALIB_CYCLES`, counting the first edge after release as cycle 1. `o_init_calib_complete` then stays high until the next reset.
- All outputs are registered. With acceptance at edge 0, `o_busy` is high from cycle 1. A request held high beyond the acceptance cycle is therefore not accepted twice.
- Write: `o_busy` is high in cycles 1..`WRITE_BUSY`. It is low in cycle `WRITE_BUSY+1`, where the next request may be accepted.
- Read with `i_busy=0`: `o_data_valid` is high for exactly one cycle, cycle `READ_LATENCY`. `o_busy` is low in cycle `READ_LATENCY+1`.
- Read with `i_busy=1`: each cycle of `i_busy=1` during RRESP extends `o_data_valid` and `o_busy` by one cycle.
- Back-to-back throughput:
  - Writes: one per `WRITE_BUSY+1` cycles.
  - Reads: one per `READ_LATENCY+1` cycles.
- Counters are `$clog2(max(param)+1)` bits wide and never wrap. Each resets to 0 on every state entry.

## Test plan
- Calibration: release reset with `CALIB_CYCLES=64`. `o_init_calib_complete` rises in cycle 64. A request held high from cycle 0 is accepted in cycle 64, not earlier.
- Write then read:
  - Write `0x0123_4567_89AB_CDEF_FEDC_BA98_7654_3210` with mask 0 to `i_addr=0x40`.
  - Read the same address. `o_data` must equal the written value, with `o_data_valid` in cycle 8 after read acceptance.
- Byte mask:
  - Pre-fill line `0x48` with all `0xFF` bytes.
  - Write all `0x00` with `i_mask=0x00FF`.
  - A read must return `0x0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF`.
- Back-pressure: hold `i_busy=1` for 5 cycles when the read response arrives. `o_data_valid` stays high 6 cycles with constant `o_data`, and `o_busy` drops the cycle after consumption.
- Aliasing and collision:
  - A write to `i_addr=0x40 + (MEM_DEPTH<<3)` must change what a read of `0x40` returns.
  - Simultaneous `i_ren=i_wen=1` performs only the write, and no `o_data_valid` follows.
- Reset mid-read: assert `reset` in cycle 3 of RWAIT. `o_data_valid` never pulses, all outputs return to reset values, and data written before the reset reads back intact after recalibration.

Source files
------------

// File: rtl/dram_bram_model.sv
// Block-RAM stand-in for the DDR3 user-side request/response interface.
// Emulates calibration delay, fixed read latency with back-pressure, and write busy time.
module dram_bram_model #(
  parameter int APP_ADDR_WIDTH = 28,
  parameter int APP_DATA_WIDTH = 128,
  parameter int APP_MASK_WIDTH = 16,
  parameter int MEM_DEPTH      = 1024,
  parameter int READ_LATENCY   = 8,
  parameter int WRITE_BUSY     = 2,
  parameter int CALIB_CYCLES   = 64
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      i_ren,
  input  logic                      i_wen,
  input  logic [APP_ADDR_WIDTH-2:0] i_addr,
  input  logic [APP_DATA_WIDTH-1:0] i_data,
  input  logic [APP_MASK_WIDTH-1:0] i_mask,
  input  logic                      i_busy,
  output logic                      o_init_calib_complete,
  output logic [APP_DATA_WIDTH-1:0] o_data,
  output logic                      o_data_valid,
  output logic                      o_busy
);
  localparam int LW   = $clog2(MEM_DEPTH);
  localparam int MAXA = (READ_LATENCY > WRITE_BUSY) ? READ_LATENCY : WRITE_BUSY;
  localparam int MAXP = (MAXA > CALIB_CYCLES) ? MAXA : CALIB_CYCLES;
  localparam int CW   = $clog2(MAXP + 1);
  localparam logic [CW-1:0] CAL_LAST = CW'(CALIB_CYCLES - 1);
  localparam logic [CW-1:0] WB_LAST  = CW'(WRITE_BUSY - 1);
  localparam logic [CW-1:0] RL_LAST  = CW'((READ_LATENCY > 1) ? READ_LATENCY - 2 : 0);

  typedef enum logic [2:0] {CALIB, IDLE, WBUSY, RWAIT, RRESP} state_t;

  state_t                    r_state;
  logic [CW-1:0]             r_cnt;
  logic [APP_DATA_WIDTH-1:0] r_mem [MEM_DEPTH];
  logic [APP_DATA_WIDTH-1:0] r_line;

  logic [LW-1:0]             w_idx;
  logic                      w_acc, w_wr, w_rd;
  logic [APP_DATA_WIDTH-1:0] w_rdata;
  logic                      w_unused_addr;

  // Upper address bits alias onto the same lines; low 3 bits select 16-bit units within a line.
  assign w_idx         = i_addr[3 +: LW];
  assign w_unused_addr = ^i_addr;
  assign w_acc         = (i_ren | i_wen) & ~o_busy & o_init_calib_complete;
  assign w_wr          = w_acc & i_wen;
  assign w_rd          = w_acc & i_ren & ~i_wen;
  assign w_rdata       = r_mem[w_idx];

  // Storage is deliberately outside the reset domain so contents survive a reset.
  always_ff @(posedge clock) begin
    if (w_wr) begin
      for (int k = 0; k < APP_MASK_WIDTH; k++)
        if (!i_mask[k]) r_mem[w_idx][8*k +: 8] <= i_data[8*k +: 8];
    end
    if (w_rd) r_line <= r_mem[w_idx];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state               <= CALIB;
      r_cnt                 <= '0;
      o_init_calib_complete <= 1'b0;
      o_busy                <= 1'b1;
      o_data_valid          <= 1'b0;
      o_data                <= '0;
    end else begin
      case (r_state)
        CALIB: begin
          if (r_cnt == CAL_LAST) begin
            r_state               <= IDLE;
            r_cnt                 <= '0;
            o_init_calib_complete <= 1'b1;
            o_busy                <= 1'b0;
          end else r_cnt <= r_cnt + 1'b1;
        end
        IDLE: begin
          if (w_wr) begin
            r_state <= WBUSY;
            r_cnt   <= '0;
            o_busy  <= 1'b1;
          end else if (w_rd) begin
            r_cnt  <= '0;
            o_busy <= 1'b1;
            // Single-cycle latency has no wait state: respond straight from the array.
            if (READ_LATENCY == 1) begin
              r_state      <= RRESP;
              o_data_valid <= 1'b1;
              o_data       <= w_rdata;
            end else r_state <= RWAIT;
          end
        end
        WBUSY: begin
          if (r_cnt == WB_LAST) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            o_busy  <= 1'b0;
          end else r_cnt <= r_cnt + 1'b1;
        end
        RWAIT: begin
          if (r_cnt == RL_LAST) begin
            r_state      <= RRESP;
            r_cnt        <= '0;
            o_data_valid <= 1'b1;
            o_data       <= r_line;
          end else r_cnt <= r_cnt + 1'b1;
        end
        RRESP: begin
          if (!i_busy) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            o_data_valid <= 1'b0;
            o_busy       <= 1'b0;
          end
        end
        default: begin
          r_state <= CALIB;
          r_cnt   <= '0;
        end
      endcase
    end
  end
endmodule
